// File: rtl/rs_issue_scheduler.sv
// ---------------------------------------------------------------------------
// rs_issue_scheduler
//
// Occupancy / readiness bookkeeping for the reservation station. Each entry
// walks FREE -> WAIT -> READY -> ISSUED -> FREE. The block hands the lowest
// FREE index to Dispatch, offers one READY entry per cycle to Execute using a
// round-robin pointer, and retires entries on Execute completion. No operand
// data is held here.
//
// Ports:
//   clk, rst            core clock, synchronous active-high reset
//   flush               clears every entry (protocol_err survives)
//   alloc_valid         Dispatch wants an entry
//   alloc_src_ready     instruction being allocated already has its operands
//   alloc_ready/index   a FREE entry exists / lowest FREE index
//   wake_en/index       Wakeup marks an entry's operands complete
//   issue_valid/index   entry offered to Execute
//   issue_ready         Execute accepts the offer
//   free_en/index       Execute completion, returns an ISSUED entry to FREE
//   occupancy           registered count of non-FREE entries
//   protocol_err        sticky flag for illegal wake/free events
// ---------------------------------------------------------------------------
module rs_issue_scheduler #(
   parameter  int RS_ENTRIES = 8,
   localparam int IDX_W      = $clog2(RS_ENTRIES),
   localparam int CNT_W      = $clog2(RS_ENTRIES + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             alloc_valid,
   input  logic             alloc_src_ready,
   output logic             alloc_ready,
   output logic [IDX_W-1:0] alloc_index,
   input  logic             wake_en,
   input  logic [IDX_W-1:0] wake_index,
   output logic             issue_valid,
   output logic [IDX_W-1:0] issue_index,
   input  logic             issue_ready,
   input  logic             free_en,
   input  logic [IDX_W-1:0] free_index,
   output logic [CNT_W-1:0] occupancy,
   output logic             protocol_err
);

   typedef enum logic [1:0] {
      ST_FREE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_READY  = 2'd2,
      ST_ISSUED = 2'd3
   } ent_state_e;

   ent_state_e       state_q [RS_ENTRIES];
   ent_state_e       state_d [RS_ENTRIES];
   logic [IDX_W-1:0] rr_ptr_q,   rr_ptr_d;
   logic             lock_q,     lock_d;      // an offer was refused and is being held
   logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
   logic [CNT_W-1:0] occ_q,      occ_d;
   logic             perr_q,     perr_d;

   logic             cand_found;
   logic [IDX_W-1:0] cand_idx;
   logic [IDX_W-1:0] scan_idx;
   logic             alloc_fire;
   logic             issue_fire;
   logic             free_ok;
   logic             wake_hits_alloc;

   // Lowest FREE entry: scanning downwards lets the last hit win.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      alloc_ready = 1'b0;
      alloc_index = '0;
      for (int i = RS_ENTRIES - 1; i >= 0; i--) begin
         if (state_q[i] == ST_FREE) begin
            alloc_ready = 1'b1;
            alloc_index = IDX_W'(i);
         end
      end
   end

   // Round-robin pick: first READY entry at rr_ptr, rr_ptr+1, ... The index
   // wraps naturally because RS_ENTRIES is a power of two.
   always_comb begin
      cand_found = 1'b0;
      cand_idx   = '0;
      scan_idx   = '0;
      for (int k = RS_ENTRIES - 1; k >= 0; k--) begin
         scan_idx = rr_ptr_q + IDX_W'(k);
         if (state_q[scan_idx] == ST_READY) begin
            cand_found = 1'b1;
            cand_idx   = scan_idx;
         end
      end
   end

   // A refused offer stays on the bus until accepted, even if a higher
   // priority entry becomes READY meanwhile.
   assign issue_valid = lock_q | cand_found;
   assign issue_index = lock_q ? lock_idx_q : cand_idx;

   assign alloc_fire      = alloc_valid & alloc_ready;
   assign issue_fire      = issue_valid & issue_ready;
   assign free_ok         = free_en & (state_q[free_index] == ST_ISSUED);
   assign wake_hits_alloc = wake_en & alloc_fire & (wake_index == alloc_index);

   // Each legal event targets an entry in a distinct state (alloc: FREE,
   // wake: WAIT, issue: READY, free: ISSUED), so no entry sees two updates.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      lock_d     = lock_q;
      lock_idx_d = lock_idx_q;
      occ_d      = occ_q;
      perr_d     = perr_q;

      if (flush) begin
         for (int i = 0; i < RS_ENTRIES; i++) begin
            state_d[i] = ST_FREE;
         end
         rr_ptr_d   = '0;
         lock_d     = 1'b0;
         lock_idx_d = '0;
         occ_d      = '0;
      end else begin
         if (wake_en) begin
            if (state_q[wake_index] == ST_WAIT) begin
               state_d[wake_index] = ST_READY;
            end else if ((state_q[wake_index] == ST_FREE) && !wake_hits_alloc) begin
               perr_d = 1'b1;
            end
         end

         // A wake racing its own allocation means the operands are complete.
         if (alloc_fire) begin
            state_d[alloc_index] = (alloc_src_ready || wake_hits_alloc) ? ST_READY : ST_WAIT;
         end

         if (issue_fire) begin
            state_d[issue_index] = ST_ISSUED;
            rr_ptr_d             = issue_index + IDX_W'(1);
            lock_d               = 1'b0;
         end else if (issue_valid) begin
            lock_d     = 1'b1;
            lock_idx_d = issue_index;
         end

         if (free_en) begin
            if (free_ok) begin
               state_d[free_index] = ST_FREE;
            end else begin
               perr_d = 1'b1;
            end
         end

         occ_d = occ_q + CNT_W'(alloc_fire) - CNT_W'(free_ok);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the entry-state array is real control state (FREE means empty), so it is reset like any flop.
         for (int i = 0; i < RS_ENTRIES; i++) begin
            state_q[i] <= ST_FREE;
         end
         rr_ptr_q   <= '0;
         lock_q     <= 1'b0;
         lock_idx_q <= '0;
         occ_q      <= '0;
         perr_q     <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q    <= state_d;
         rr_ptr_q   <= rr_ptr_d;
         lock_q     <= lock_d;
         lock_idx_q <= lock_idx_d;
         occ_q      <= occ_d;
         perr_q     <= perr_d;
      end
   end

   assign occupancy    = occ_q;
   assign protocol_err = perr_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// ---------------------------------------------------------------------------
// tb_rs_issue_scheduler
//
// Directed scenarios followed by a randomized run. Expected outputs come from
// a behavioural model of the entry table kept as plain integer arrays.
// ---------------------------------------------------------------------------
module tb_rs_issue_scheduler;

   localparam int N     = 8;
   localparam int IDX_W = 3;
   localparam int CNT_W = 4;

   localparam int M_FREE   = 0;
   localparam int M_WAIT   = 1;
   localparam int M_READY  = 2;
   localparam int M_ISSUED = 3;

   logic             clk;
   logic             rst;
   logic             flush;
   logic             alloc_valid;
   logic             alloc_src_ready;
   logic             alloc_ready;
   logic [IDX_W-1:0] alloc_index;
   logic             wake_en;
   logic [IDX_W-1:0] wake_index;
   logic             issue_valid;
   logic [IDX_W-1:0] issue_index;
   logic             issue_ready;
   logic             free_en;
   logic [IDX_W-1:0] free_index;
   logic [CNT_W-1:0] occupancy;
   logic             protocol_err;

   int n_checks = 0;
   int n_err    = 0;

   // Behavioural model
   int m_st [N];
   int m_rr;
   int m_held;     // index being held after a refused offer, -1 if none
   int m_occ;
   bit m_perr;

   rs_issue_scheduler #(.RS_ENTRIES(N)) dut (
      .clk             (clk),
      .rst             (rst),
      .flush           (flush),
      .alloc_valid     (alloc_valid),
      .alloc_src_ready (alloc_src_ready),
      .alloc_ready     (alloc_ready),
      .alloc_index     (alloc_index),
      .wake_en         (wake_en),
      .wake_index      (wake_index),
      .issue_valid     (issue_valid),
      .issue_index     (issue_index),
      .issue_ready     (issue_ready),
      .free_en         (free_en),
      .free_index      (free_index),
      .occupancy       (occupancy),
      .protocol_err    (protocol_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int m_lowest_free();
      for (int i = 0; i < N; i++) begin
         if (m_st[i] == M_FREE) return i;
      end
      return -1;
   endfunction

   function automatic int m_offer();
      if (m_held >= 0) return m_held;
      for (int k = 0; k < N; k++) begin
         if (m_st[(m_rr + k) % N] == M_READY) return (m_rr + k) % N;
      end
      return -1;
   endfunction

   // Picks an entry in the wanted state most of the time, otherwise any index.
   function automatic int pick(input int want);
      int q[$];
      for (int i = 0; i < N; i++) begin
         if (m_st[i] == want) q.push_back(i);
      end
      if ((q.size() == 0) || ($urandom_range(0, 9) == 0)) return int'($urandom_range(0, N - 1));
      return q[$urandom_range(0, q.size() - 1)];
   endfunction

   task automatic m_step();
      int nst [N];
      int ai, ii, wi, fi;
      bit af;
      if (rst) begin
         for (int i = 0; i < N; i++) m_st[i] = M_FREE;
         m_rr = 0; m_held = -1; m_occ = 0; m_perr = 1'b0;
         return;
      end
      if (flush) begin
         for (int i = 0; i < N; i++) m_st[i] = M_FREE;
         m_rr = 0; m_held = -1; m_occ = 0;
         return;
      end
      ai  = m_lowest_free();
      af  = alloc_valid && (ai >= 0);
      ii  = m_offer();
      wi  = int'(wake_index);
      fi  = int'(free_index);
      nst = m_st;
      if (wake_en) begin
         if (m_st[wi] == M_WAIT) nst[wi] = M_READY;
         else if ((m_st[wi] == M_FREE) && !(af && (ai == wi))) m_perr = 1'b1;
      end
      if (af) begin
         nst[ai] = (alloc_src_ready || (wake_en && (wi == ai))) ? M_READY : M_WAIT;
         m_occ++;
      end
      if (ii >= 0) begin
         if (issue_ready) begin
            nst[ii] = M_ISSUED;
            m_rr    = (ii + 1) % N;
            m_held  = -1;
         end else begin
            m_held = ii;
         end
      end
      if (free_en) begin
         if (m_st[fi] == M_ISSUED) begin
            nst[fi] = M_FREE;
            m_occ--;
         end else begin
            m_perr = 1'b1;
         end
      end
      m_st = nst;
   endtask

   task automatic check_model();
      int fi;
      int oi;
      fi = m_lowest_free();
      oi = m_offer();
      check("m_alloc_ready", alloc_ready, (fi >= 0));
      if (fi >= 0) check("m_alloc_index", alloc_index, fi);
      check("m_issue_valid", issue_valid, (oi >= 0));
      if (oi >= 0) check("m_issue_index", issue_index, oi);
      check("m_occupancy", occupancy, m_occ);
      check("m_protocol_err", protocol_err, m_perr);
   endtask

   // Advance one clock: update the model from the current inputs, then
   // compare DUT outputs just after the edge.
   task automatic tick();
      m_step();
      @(posedge clk);
      #1;
      check_model();
   endtask

   task automatic drive(input bit av, input bit src, input bit we, input int wi,
                        input bit ir, input bit fe, input int fi);
      rst             = 1'b0;
      flush           = 1'b0;
      alloc_valid     = av;
      alloc_src_ready = src;
      wake_en         = we;
      wake_index      = IDX_W'(wi);
      issue_ready     = ir;
      free_en         = fe;
      free_index      = IDX_W'(fi);
   endtask

   task automatic do_reset();
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < N; i++) m_st[i] = M_FREE;
      m_rr = 0; m_held = -1; m_occ = 0; m_perr = 1'b0;

      // Reset state
      drive(0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;
      tick();
      rst = 1'b0;
      check("rst_alloc_ready", alloc_ready, 1);
      check("rst_alloc_index", alloc_index, 0);
      check("rst_issue_valid", issue_valid, 0);
      check("rst_issue_index", issue_index, 0);
      check("rst_occupancy", occupancy, 0);
      check("rst_protocol_err", protocol_err, 0);

      // Fill all eight entries, none ready
      for (int i = 0; i < N; i++) begin
         drive(1, 0, 0, 0, 0, 0, 0);
         check("fill_alloc_index", alloc_index, i);
         tick();
      end
      drive(0, 0, 0, 0, 0, 0, 0);
      check("fill_occupancy", occupancy, 8);
      check("fill_alloc_ready", alloc_ready, 0);
      check("fill_issue_valid", issue_valid, 0);

      // Wake 5 then 2; each is offered the cycle after its wake
      drive(0, 0, 1, 5, 1, 0, 0);
      tick();
      check("wake5_offer", issue_index, 5);
      drive(0, 0, 1, 2, 1, 0, 0);
      tick();
      check("wake2_offer", issue_index, 2);
      drive(0, 0, 0, 0, 1, 0, 0);
      tick();
      check("after_issue_valid", issue_valid, 0);

      // 1 refused and held while 3 and 6 become ready (rr_ptr is 3)
      drive(0, 0, 1, 1, 0, 0, 0);
      tick();
      check("hold_offer_a", issue_index, 1);
      drive(0, 0, 1, 3, 0, 0, 0);
      tick();
      check("hold_offer_b", issue_index, 1);
      drive(0, 0, 1, 6, 0, 0, 0);
      tick();
      check("hold_offer_c", issue_index, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      tick();
      check("hold_offer_d", issue_index, 1);
      drive(0, 0, 0, 0, 1, 0, 0);
      tick();
      check("rr_next_3", issue_index, 3);
      tick();
      check("rr_next_6", issue_index, 6);
      tick();
      check("rr_drained", issue_valid, 0);

      // Issue 4, then free 4 while Dispatch waits for a slot
      drive(0, 0, 1, 4, 1, 0, 0);
      tick();
      tick();
      drive(1, 1, 0, 0, 0, 1, 4);
      check("free_alloc_blocked", alloc_ready, 0);
      check("free_alloc_occ_before", occupancy, 8);
      tick();
      drive(1, 1, 0, 0, 0, 0, 0);
      check("freed_alloc_ready", alloc_ready, 1);
      check("freed_alloc_index", alloc_index, 4);
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      check("free_alloc_occ_after", occupancy, 8);
      check("realloc_offer", issue_index, 4);

      // Wake on a FREE entry sets the sticky error; flush keeps it
      drive(0, 0, 0, 0, 0, 1, 1);
      tick();
      check("legal_free_perr", protocol_err, 0);
      drive(0, 0, 1, 1, 0, 0, 0);
      tick();
      check("wake_free_perr", protocol_err, 1);
      check("wake_free_unchanged", alloc_index, 1);
      drive(0, 0, 0, 0, 0, 0, 0);
      flush = 1'b1;
      tick();
      check("flush_keeps_perr", protocol_err, 1);
      do_reset();
      check("rst_clears_perr", protocol_err, 0);

      // Free on a WAIT entry is ignored and flagged
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      drive(0, 0, 0, 0, 0, 1, 0);
      tick();
      check("free_wait_perr", protocol_err, 1);
      check("free_wait_occ", occupancy, 1);
      do_reset();

      // Wake racing its own allocation makes the entry READY, no error
      drive(1, 0, 1, 0, 0, 0, 0);
      tick();
      check("alloc_wake_perr", protocol_err, 0);
      check("alloc_wake_valid", issue_valid, 1);
      check("alloc_wake_index", issue_index, 0);
      do_reset();

      // Six occupied, flush alongside alloc and issue accept
      for (int i = 0; i < 6; i++) begin
         drive(1, 1, 0, 0, 0, 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 1, 0, 0);
      tick();
      check("pre_flush_occ", occupancy, 6);
      drive(1, 1, 0, 0, 1, 0, 0);
      flush = 1'b1;
      tick();
      check("flush_occ", occupancy, 0);
      check("flush_issue_valid", issue_valid, 0);
      check("flush_alloc_index", alloc_index, 0);
      drive(1, 0, 0, 0, 0, 0, 0);
      tick();
      drive(1, 1, 1, 0, 0, 0, 0);
      tick();
      check("flush_rr_reset", issue_index, 0);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         drive($urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, pick(M_WAIT),
               $urandom_range(0, 9) < 7,
               $urandom_range(0, 9) < 4, pick(M_ISSUED));
         rst   = ($urandom_range(0, 399) == 0);
         flush = ($urandom_range(0, 59) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
